// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/stall controller: per-stage load enables, flush/bubble steering,
// mul/div wait tracking and saturating performance counters.
module pipeline_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imem_pending,
  input  logic             imem_resp,
  input  logic             dmem_pending,
  input  logic             dmem_resp,
  input  logic             muldiv_start,
  input  logic             muldiv_done,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             ex_valid,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd,
  input  logic             misprediction,
  output logic             load_pc,
  output logic             load_if_id,
  output logic             load_id_ex,
  output logic             load_ex_mem,
  output logic             load_mem_wb,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             bubble_id_ex,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [0:0] {RUN, MULDIV_WAIT} state_t;

  state_t state;
  logic   pending_flush;
  logic   mem_stall;
  logic   stall;
  logic   hazard;
  logic   flush_now;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    mem_stall = (imem_pending & ~imem_resp) | (dmem_pending & ~dmem_resp);
    stall     = mem_stall | ((state == RUN) & muldiv_start)
              | ((state == MULDIV_WAIT) & ~muldiv_done);
    hazard    = id_valid & ex_valid & ex_is_load & (ex_rd != 5'd0)
              & ((ex_rd == id_rs1) | (ex_rd == id_rs2));
    flush_now = (misprediction | pending_flush) & ~stall;
  end

  // Priority: reset, stall, flush, load-use hazard, normal advance.
  always_comb begin
    load_pc      = 1'b1;
    load_if_id   = 1'b1;
    load_id_ex   = 1'b1;
    load_ex_mem  = 1'b1;
    load_mem_wb  = 1'b1;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    bubble_id_ex = 1'b0;
    if (rst || stall) begin
      load_pc     = 1'b0;
      load_if_id  = 1'b0;
      load_id_ex  = 1'b0;
      load_ex_mem = 1'b0;
      load_mem_wb = 1'b0;
    end else if (flush_now) begin
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else if (hazard) begin
      load_pc      = 1'b0;
      load_if_id   = 1'b0;
      bubble_id_ex = 1'b1;
    end
  end

  // A mul/div start seen during a memory stall is ignored; EX reasserts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RUN;
      pending_flush <= 1'b0;
      stall_cnt     <= '0;
      bubble_cnt    <= '0;
      flush_cnt     <= '0;
    end else begin
      case (state)
        RUN:         if (muldiv_start & ~mem_stall) state <= MULDIV_WAIT;
        MULDIV_WAIT: if (muldiv_done & ~mem_stall)  state <= RUN;
        default:     state <= RUN;
      endcase
      if (flush_now)
        pending_flush <= 1'b0;
      else if (misprediction & stall)
        pending_flush <= 1'b1;
      if (stall)        stall_cnt  <= sat_inc(stall_cnt);
      if (bubble_id_ex) bubble_cnt <= sat_inc(bubble_cnt);
      if (flush_now)    flush_cnt  <= sat_inc(flush_cnt);
    end
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, giving the width of each performance counter.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port imem_pending, input, 1: the instruction fetch request is outstanding.
REQ-005 SHALL have port imem_resp, input, 1: the instruction memory response is valid this cycle.
REQ-006 SHALL have port dmem_pending, input, 1: a data read or write in MEM is outstanding.
REQ-007 SHALL have port dmem_resp, input, 1: the data memory response is valid this cycle.
REQ-008 SHALL have port muldiv_start, input, 1: a multi-cycle mul/div in EX begins this cycle.
REQ-009 SHALL have port muldiv_done, input, 1: the mul/div result is valid this cycle.
REQ-010 SHALL have ports id_valid (1), id_rs1 (5) and id_rs2 (5), all inputs: the instruction in ID and its source registers.
REQ-011 SHALL have ports ex_valid (1), ex_is_load (1) and ex_rd (5), all inputs: the instruction in EX.
REQ-012 SHALL have port misprediction, input, 1: the branch resolved in EX was mispredicted.
REQ-013 SHALL have ports load_pc, load_if_id, load_id_ex, load_ex_mem and load_mem_wb, each output, 1, the per-stage latch load enables.
REQ-014 SHALL have ports flush_if_id, flush_id_ex and bubble_id_ex, each output, 1: force valid_i=0 into the named latch.
REQ-015 SHALL have ports stall_cnt, bubble_cnt and flush_cnt, each output, CNT_W wide, saturating performance counters.

Function
REQ-016 SHALL implement FSM states RUN, MULDIV_WAIT; plus register pending_flush.
REQ-017 SHALL compute mem_stall = (imem_pending & ~imem_resp) | (dmem_pending & ~dmem_resp).
REQ-018 SHALL compute stall = mem_stall | (state==RUN & muldiv_start) | (state==MULDIV_WAIT & ~muldiv_done).
REQ-019 SHALL compute hazard = id_valid & ex_valid & ex_is_load & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2).
REQ-020 SHALL compute flush_now = (misprediction | pending_flush) & ~stall.
REQ-021 SHALL generate all outputs combinationally in the same cycle, so that latches sample them at the next edge.
REQ-022 SHALL, when stall is asserted, drive all five load_* signals 0, flushes 0 and bubble 0; priority is highest.
REQ-023 SHALL, when flush_now is asserted, drive all load_* 1, flush_if_id=1, flush_id_ex=1 and bubble_id_ex=0; priority is second.
REQ-024 SHALL, when hazard is asserted without stall or flush_now, drive load_pc=0, load_if_id=0, the other loads 1 and bubble_id_ex=1.
REQ-025 SHALL otherwise drive all load_* 1 and all flush/bubble signals 0.
REQ-026 SHALL transition RUN->MULDIV_WAIT when muldiv_start & ~mem_stall; muldiv_start while mem_stall is ignored, since EX holds and reasserts it.
REQ-027 SHALL transition MULDIV_WAIT->RUN on muldiv_done & ~mem_stall, and remain in MULDIV_WAIT otherwise.
REQ-028 SHALL set pending_flush when misprediction & stall; SHALL clear it in the cycle flush_now is asserted; a simultaneous set and clear resolves to clear.
REQ-029 SHALL increment stall_cnt by 1 per cycle with stall=1, bubble_cnt per cycle with bubble_id_ex=1, and flush_cnt per cycle with flush_now=1.
REQ-030 SHALL saturate each counter at 2^CNT_W-1 with no wrap.

Reset
REQ-031 SHALL, on rst=1 at a clock edge, set state=RUN, pending_flush=0 and all counters to 0, overriding every other update, including mid-MULDIV_WAIT.
REQ-032 SHALL, while rst=1, drive all load_*, flush_* and bubble_id_ex to 0 regardless of inputs.

Verification
REQ-033 SHALL cover: imem_pending=1 with imem_resp=0 for 3 cycles then 1 -> all loads 0 for 3 cycles, all loads 1 on the resp cycle, stall_cnt=3.
REQ-034 SHALL cover: ex_valid=1, ex_is_load=1, ex_rd=5, id_valid=1, id_rs2=5 -> load_pc=0, load_if_id=0, load_id_ex=1, bubble_id_ex=1 and bubble_cnt+1; repeated with ex_rd=0 -> no bubble.
REQ-035 SHALL cover: misprediction=1 in the same cycle dmem stall begins, 2 stall cycles -> no flush during stall; flush_if_id=flush_id_ex=1 on the first non-stall cycle; pending_flush then 0 and flush_cnt=1.
REQ-036 SHALL cover: muldiv_start pulse, muldiv_done after 4 cycles -> loads 0 for cycles 0-3, loads 1 on the done cycle, state back to RUN.
REQ-037 SHALL cover: rst asserted in MULDIV_WAIT with pending_flush=1 -> next cycle state=RUN, pending_flush=0, counters 0, outputs 0 during rst.
REQ-038 SHALL cover: CNT_W=4 with 20 consecutive stall cycles -> stall_cnt holds at 15.
